bram_result_reader: RTL
=======================

Name: bram_result_reader

Overview:
- Reads the result rows that the accumulate engine writes into BRAM1 and streams them out on a valid/ready interface toward the host/DMA side.
- Each BRAM1 row holds the four 32-bit core results, so each row is 128 bits.
- Same start/count control style and IDLE/RUN/DONE state outputs as the accumulate engine.
- Read-only on BRAM1. Absorbs the BRAM's 1-cycle read latency and downstream backpressure with a 2-entry output FIFO.

Parameters:
- CNT_BIT, 8, width of run_count_i and of the internal issue/transfer counters.
- DWIDTH, 128, BRAM1 row width = output data width.
- AWIDTH, 8, BRAM1 address width.
- MEM_SIZE, 256, BRAM1 depth in rows.

Ports:
- clk  input  1  clock.
- reset_n  input  1  asynchronous, active-low reset.
- start_run_i  input  1  start pulse; sampled only in IDLE.
- run_count_i  input  CNT_BIT  number of rows to read, starting at address 0.
- q_b1_i  input  DWIDTH  BRAM1 read data, valid in the cycle after a ce/addr cycle.
- addr_b1_o  output  AWIDTH  BRAM1 address.
- ce_b1_o  output  1  BRAM1 chip enable.
- we_b1_o  output  1  BRAM1 write enable; tied 0.
- d_b1_o  output  DWIDTH  BRAM1 write data; tied 0.
- m_valid_o  output  1  stream data valid.
- m_ready_i  input  1  stream sink ready.
- m_data_o  output  DWIDTH  stream data (FIFO head).
- idle_o  output  1  state == IDLE.
- run_o  output  1  state == RUN.
- done_o  output  1  state == DONE; a one-cycle pulse.

Behaviour:
- Clock and reset: one clock (clk). reset_n is asynchronous and active-low. The polarity and synchronicity are fixed.
- Reset values:
  - State = IDLE, so idle_o=1, run_o=0, done_o=0.
  - ce_b1_o=0, addr_b1_o=0, m_valid_o=0, m_data_o=0.
  - All counters and FIFO pointers are 0.
- Reset mid-operation aborts immediately. FIFO contents and any in-flight read are discarded.
- State IDLE:
  - On start_run_i=1, latch run_count_i into cnt_r.
  - Go to RUN if run_count_i != 0; otherwise go to DONE.
- State RUN, read issue:
  - Define issued = reads issued so far, inflight = a read issued last cycle (0/1), occ = FIFO occupancy (0..2), pop = m_valid_o & m_ready_i.
  - A read issues in a cycle when issued < cnt_r AND occ + inflight - pop < 2.
  - On issue: ce_b1_o=1, addr_b1_o = issued; the address counter then increments.
  - When not issuing, ce_b1_o=0 and addr_b1_o holds its last value.
  - we_b1_o is always 0.
- State RUN, data capture and output:
  - q_b1_i is pushed into the FIFO at the end of the cycle after the issue cycle.
  - m_valid_o = (occ != 0), registered from the FIFO state. m_data_o = FIFO head.
  - Latency: first ce cycle T, data captured at the end of T+1, m_valid_o=1 in T+2.
  - With m_ready_i held at 1: one row per cycle, no bubbles after the first.
- Handshake rules:
  - Once m_valid_o is asserted, m_data_o stays stable until accepted.
  - m_valid_o never drops without a transfer.
  - Simultaneous push and pop with occ=2 cannot occur, because the issue rule guarantees no overflow.
- RUN to DONE: after the cnt_r-th transfer (pop), go to DONE in the next cycle.
- State DONE: done_o=1 for exactly one cycle, then IDLE unconditionally.
- start_run_i asserted in RUN or DONE is ignored.
- Addresses: rows 0 .. cnt_r-1.
  - If cnt_r > MEM_SIZE, the address wraps modulo 2^AWIDTH. No error is flagged.
  - With the defaults (CNT_BIT=8, AWIDTH=8) the maximum count is 255, which stays in range.
- d_b1_o is always 0.

Optional Feature:
- Macro: BRAM_READER_CHECKSUM_EN.
- When defined:
  - Extra port checksum_o, output, 32 bits.
  - Running sum mod 2^32 of the four 32-bit lanes of every transferred word.
  - Cleared to 0 on reset and on the IDLE→RUN/DONE transition.
  - Holds its value after DONE until the next start.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Basic stream: BRAM1[0..3]={0x..01,0x..02,0x..03,0x..04}, run_count_i=4, m_ready_i=1.
  - Required: 4 beats in order on consecutive cycles.
  - First m_valid_o 2 cycles after the first ce_b1_o.
  - done_o pulses once; the cycle after, idle_o=1.
- Backpressure: run_count_i=6, m_ready_i toggled 1,0,0,1,1,0,...
  - Required: all 6 rows in order, none dropped or duplicated.
  - Data stable while stalled.
  - FIFO never exceeds 2; ce_b1_o deasserts while the FIFO is full.
- Zero count: run_count_i=0 with a start pulse.
  - Required: no ce_b1_o and no m_valid_o; done_o pulses on the cycle after start; back to IDLE.
- Ignored start: start_run_i pulsed during RUN with a different run_count_i.
  - Required: the original count completes unchanged.
- Async reset mid-run: reset_n=0 after 3 of 8 beats.
  - Required: immediately idle_o=1, m_valid_o=0, ce_b1_o=0.
  - A new start with run_count_i=2 then reads from address 0.
- Checksum (with BRAM_READER_CHECKSUM_EN): 2 rows with all lanes 0xFFFFFFFF.
  - Required: checksum_o=0xFFFFFFF8 at DONE.

Source files
------------

// File: rtl/bram_result_reader.sv
// Streams BRAM1 result rows 0..count-1 out on a valid/ready port through a 2-entry FIFO.
// Optional running lane checksum output enabled by BRAM_READER_CHECKSUM_EN.
module bram_result_reader #(
  parameter int unsigned CNT_BIT  = 8,
  parameter int unsigned DWIDTH   = 128,
  parameter int unsigned AWIDTH   = 8,
  parameter int unsigned MEM_SIZE = 256
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start_run_i,
  input  logic [CNT_BIT-1:0] run_count_i,
  input  logic [DWIDTH-1:0]  q_b1_i,
  output logic [AWIDTH-1:0]  addr_b1_o,
  output logic               ce_b1_o,
  output logic               we_b1_o,
  output logic [DWIDTH-1:0]  d_b1_o,
  output logic               m_valid_o,
  input  logic               m_ready_i,
  output logic [DWIDTH-1:0]  m_data_o,
`ifdef BRAM_READER_CHECKSUM_EN
  output logic [31:0]        checksum_o,
`endif
  output logic               idle_o,
  output logic               run_o,
  output logic               done_o
);

  if (MEM_SIZE > (1 << AWIDTH)) begin : g_size_chk
    $error("MEM_SIZE exceeds the BRAM1 address space");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [CNT_BIT-1:0] cnt_q, issued_q, xfer_q;
  logic               inflight_q;
  logic [DWIDTH-1:0]  fifo_q [2];
  logic               wr_ptr_q, rd_ptr_q;
  logic [1:0]         occ_q;
  logic [AWIDTH-1:0]  addr_q;

  logic       start, issue, push, pop, last_xfer;
  logic [2:0] pending;

  assign start   = (state_q == StIdle) && start_run_i;
  assign push    = inflight_q;
  assign pop     = (occ_q != 2'd0) && m_ready_i;
  // Slots already claimed after this cycle: buffered rows plus the read in flight, minus a pop.
  assign pending = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue   = (state_q == StRun) && (issued_q < cnt_q) && (pending < 3'd2);
  assign last_xfer = pop && (xfer_q == cnt_q - CNT_BIT'(1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_run_i) state_d = (run_count_i != '0) ? StRun : StDone;
      end
      StRun: begin
        if (last_xfer) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      issued_q   <= '0;
      xfer_q     <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
      addr_q     <= '0;
      for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      occ_q      <= occ_q + {1'b0, push} - {1'b0, pop};
      if (start) begin
        cnt_q    <= run_count_i;
        issued_q <= '0;
        xfer_q   <= '0;
      end
      if (issue) begin
        issued_q <= issued_q + CNT_BIT'(1);
        addr_q   <= AWIDTH'(issued_q);
      end
      if (push) begin
        fifo_q[wr_ptr_q] <= q_b1_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        xfer_q   <= xfer_q + CNT_BIT'(1);
      end
    end
  end

  assign ce_b1_o   = issue;
  assign addr_b1_o = issue ? AWIDTH'(issued_q) : addr_q;
  assign we_b1_o   = 1'b0;
  assign d_b1_o    = '0;
  assign m_valid_o = (occ_q != 2'd0);
  assign m_data_o  = fifo_q[rd_ptr_q];
  assign idle_o    = (state_q == StIdle);
  assign run_o     = (state_q == StRun);
  assign done_o    = (state_q == StDone);

`ifdef BRAM_READER_CHECKSUM_EN
  logic [31:0] lane_sum, sum_q;

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < DWIDTH / 32; i++) lane_sum = lane_sum + m_data_o[32*i +: 32];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= '0;
    end else if (start) begin
      sum_q <= '0;
    end else if (pop) begin
      sum_q <= sum_q + lane_sum;
    end
  end

  assign checksum_o = sum_q;
`endif

endmodule
